decode_issue_ctrl: RTL
======================

DECODE_ISSUE_CTRL -- requirements
Module: decode_issue_ctrl

Interface
REQ-001 Parameter: LOAD_USE_BUBBLES, default 1, range 0..3; bubble cycles inserted after an issued load for dependent instructions.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 flush  in  1  discard all buffered instructions and the bubble state.
REQ-005 in_valid / in_ready  in / out  1 / 1  fetch-side handshake.
REQ-006 in_instr / in_pc  in / in  32 / 64  instruction word and its PC.
REQ-007 out_valid / out_ready  out / in  1 / 1  execute-side handshake.
REQ-008 out_instr / out_pc / out_imm  out  32 / 64 / 64  head instruction, its PC, and its sign-extended immediate.
REQ-009 out_fmt  out  2  immediate class: 0 OTHER, 1 S, 2 B, 3 I.

Function
REQ-010 Buffer: 2-entry FIFO; occupancy states EMPTY, ONE, FULL.
REQ-011 Buffer entries: instr, pc, imm, fmt, with imm/fmt computed at enqueue.
REQ-012 Enqueue on in_valid && in_ready; dequeue on out_valid && out_ready.
REQ-013 in_ready = (state != FULL); it is a registered-state function only, with no combinational path from out_ready.
REQ-014 Occupancy transitions: FULL + dequeue -> ONE, even if in_valid is high.
REQ-015 Occupancy transitions: ONE + enqueue + dequeue -> ONE, with the new entry becoming head.
REQ-016 Occupancy transitions: EMPTY + enqueue -> ONE, with out_valid high the next cycle (latency 1).
REQ-017 Immediate, opcode [6:0]=0100011 (S): imm = sext({instr[31:25], instr[11:7]}).
REQ-018 Immediate, opcode 1100011 (B): imm = sext({instr[31], instr[7], instr[30:25], instr[11:8]}), unshifted.
REQ-019 Immediate, opcodes 0010011 and 0000011 (I): imm = sext(instr[31:20]).
REQ-020 Immediate, all other opcodes: imm = sext(instr[31:0]) to 64 bits.
REQ-021 Load tracking: on dequeue of an opcode-0000011 instruction, latch rd = instr[11:7] and load bubble_cnt = LOAD_USE_BUBBLES.
REQ-022 bubble_cnt decrements by 1 each cycle while nonzero, saturating at 0.
REQ-023 Dependency test: the head depends on the latched rd when rd != 0 and (rs1 = instr[19:15] == rd, or rs2 = instr[24:20] == rd with head opcode in {0100011, 1100011, 0110011}).
REQ-024 out_valid = (state != EMPTY) && !(bubble_cnt != 0 && head depends on latched rd); independent heads issue without delay.
REQ-025 A new load dequeue overrides any pending rd and bubble_cnt.
REQ-026 When LOAD_USE_BUBBLES=0, no bubbles are ever inserted.
REQ-027 flush: next state EMPTY and bubble_cnt = 0.
REQ-028 flush priority: in_valid/in_ready in the flush cycle are ignored (no enqueue), and out_valid is forced 0 in that cycle.
REQ-029 out_* data are held stable while out_valid && !out_ready.

Reset
REQ-030 On reset_n low, asynchronously: state EMPTY, bubble_cnt 0, latched rd 0, out_valid 0, in_ready held 0.
REQ-031 On reset release: in_ready rises on the first posedge after release; out_instr/out_pc/out_imm/out_fmt read 0 while EMPTY.
REQ-032 Reset asserted mid-transfer drops all buffered entries; no partial issue occurs.

Configuration
REQ-033 Macro DECODE_PERF_CNT_EN defined: adds output perf_bubbles (out, 32).
REQ-034 perf_bubbles increments each cycle that out_valid is suppressed by REQ-024, wraps at 2^32, and resets to 0.
REQ-035 perf_bubbles is not cleared by flush.
REQ-036 Macro DECODE_PERF_CNT_EN undefined: the port and counter are absent, with no other behavioural change.

Structure
REQ-037 Package decode_pkg: opcode constants OP_STORE, OP_BRANCH, OP_IMM, OP_LOAD, OP_REG; enum imm_fmt_t {FMT_OTHER, FMT_S, FMT_B, FMT_I}; occupancy enum.
REQ-038 Sub-module imm_gen (combinational: instr -> imm, fmt) implements REQ-017..REQ-020 and is instantiated once on the enqueue path.

Verification
REQ-039 Immediate decode: enqueue 0xFE000FA3 (S) -> out_imm 0xFFFF_FFFF_FFFF_FFFF, out_fmt 1; enqueue 0x00500093 (I) -> out_imm 5, out_fmt 3.
REQ-040 Back-pressure: 3 back-to-back valid instrs with out_ready=0 -> in_ready low after 2 accepted; raise out_ready -> all 3 issue in order, no loss or duplication.
REQ-041 Load-use stall: issue 0x0000B103 (ld x2), next head 0x002081B3 (add, rs2=x2), LOUD_USE_BUBBLES=1 -> out_valid low 1 cycle, then issue; independent 0x00418233 issues with no gap.
REQ-042 Flush during FULL with in_valid high -> next cycle EMPTY, out_valid 0, flush-cycle input not captured, bubble_cnt 0.
REQ-043 Async reset asserted between clock edges with FULL buffer -> out_valid and in_ready drop immediately; after release, first enqueue issues 1 cycle later.
REQ-044 With DECODE_PERF_CNT_EN and LOAD_USE_BUBBLES=3, a dependent load-use pair -> perf_bubbles = 3.

Source files
------------

// File: rtl/decode_issue_ctrl_pkg.sv
// Shared decode definitions: opcode constants, immediate classes, buffer occupancy
// states and the buffered-entry record.
package decode_pkg;

    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [1:0] {
        FMT_OTHER = 2'd0,
        FMT_S     = 2'd1,
        FMT_B     = 2'd2,
        FMT_I     = 2'd3
    } imm_fmt_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        imm_fmt_t    fmt;
    } entry_t;

    function automatic logic [63:0] sext12(input logic [11:0] v);
        return {{52{v[11]}}, v};
    endfunction

    // Only these formats actually read rs2, so only they can hazard on it.
    function automatic logic reads_rs2(input logic [6:0] op);
        return (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_REG);
    endfunction

endpackage

// File: rtl/decode_issue_ctrl_if.sv
// Fetch-side and execute-side handshake bundle for decode_issue_ctrl.
// master = the surrounding pipeline, slave = the decode/issue block.
interface decode_issue_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [63:0] out_imm;
    logic [1:0]  out_fmt;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt
    );
endinterface

// File: rtl/decode_issue_ctrl_imm_gen.sv
// Combinational immediate extractor: classifies the opcode and sign-extends the
// matching immediate field to 64 bits (B-type left unshifted).
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    output logic [63:0] imm,
    output imm_fmt_t    fmt
);

    always_comb begin
        imm = {{32{instr[31]}}, instr};
        fmt = FMT_OTHER;
        case (instr[6:0])
            OP_STORE: begin
                imm = sext12({instr[31:25], instr[11:7]});
                fmt = FMT_S;
            end
            OP_BRANCH: begin
                imm = sext12({instr[31], instr[7], instr[30:25], instr[11:8]});
                fmt = FMT_B;
            end
            OP_IMM, OP_LOAD: begin
                imm = sext12(instr[31:20]);
                fmt = FMT_I;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode/issue control: 2-entry buffer of pre-decoded instructions with load-use
// bubble insertion. Defining DECODE_PERF_CNT_EN adds the perf_bubbles stall counter.
module decode_issue_ctrl
    import decode_pkg::*;
#(
    parameter int unsigned LOAD_USE_BUBBLES = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    decode_issue_ctrl_if.slave bus
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]        perf_bubbles
`endif
);

    logic [63:0] enq_imm;
    imm_fmt_t    enq_fmt;
    entry_t      enq_entry;

    occ_state_t  state_q, state_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        in_ready_q, in_ready_d;
    logic [1:0]  bubble_q, bubble_d;
    logic [4:0]  ld_rd_q, ld_rd_d;

    entry_t      slot_data [2];
    entry_t      head;
    logic [6:0]  head_op;
    logic [4:0]  head_rs1;
    logic [4:0]  head_rs2;
    logic        head_dep;
    logic        stall;
    logic        head_present;
    logic        out_valid;
    logic        enq;
    logic        deq;

    imm_gen u_imm_gen (
        .instr (bus.in_instr),
        .imm   (enq_imm),
        .fmt   (enq_fmt)
    );

    assign enq_entry = '{instr: bus.in_instr, pc: bus.in_pc, imm: enq_imm, fmt: enq_fmt};

    // in_ready_q tracks state != FULL but stays low throughout reset.
    assign enq = bus.in_valid && in_ready_q && !flush;
    assign deq = out_valid && bus.out_ready;

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        entry_t slot_q, slot_d;
        logic   wr_en;

        assign wr_en = enq && (wr_ptr_q == 1'(gi));

        always_comb begin
            slot_d = slot_q;
            if (wr_en) begin
                slot_d = enq_entry;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                slot_q <= '0;
            end else begin
                slot_q <= slot_d;
            end
        end

        assign slot_data[gi] = slot_q;
    end

    assign head         = slot_data[rd_ptr_q];
    assign head_present = (state_q != OCC_EMPTY);
    assign head_op      = head.instr[6:0];
    assign head_rs1     = head.instr[19:15];
    assign head_rs2     = head.instr[24:20];

    assign head_dep = (ld_rd_q != 5'd0) &&
                      ((head_rs1 == ld_rd_q) || ((head_rs2 == ld_rd_q) && reads_rs2(head_op)));
    assign stall     = (bubble_q != 2'd0) && head_dep;
    assign out_valid = head_present && !stall && !flush;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        bubble_d = bubble_q;
        ld_rd_d  = ld_rd_q;

        if (flush) begin
            state_d  = OCC_EMPTY;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            bubble_d = 2'd0;
        end else begin
            if (enq) wr_ptr_d = ~wr_ptr_q;
            if (deq) rd_ptr_d = ~rd_ptr_q;

            case (state_q)
                OCC_EMPTY: if (enq) state_d = OCC_ONE;
                OCC_ONE: begin
                    if (enq && !deq)      state_d = OCC_FULL;
                    else if (deq && !enq) state_d = OCC_EMPTY;
                end
                OCC_FULL:  if (deq) state_d = OCC_ONE;
                default:   state_d = OCC_EMPTY;
            endcase

            // A freshly issued load restarts the window, overriding any older one.
            if (deq && (head_op == OP_LOAD)) begin
                ld_rd_d  = head.instr[11:7];
                bubble_d = 2'(LOAD_USE_BUBBLES);
            end else if (bubble_q != 2'd0) begin
                bubble_d = bubble_q - 2'd1;
            end
        end

        in_ready_d = (state_d != OCC_FULL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= OCC_EMPTY;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            in_ready_q <= 1'b0;
            bubble_q   <= 2'd0;
            ld_rd_q    <= 5'd0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            in_ready_q <= in_ready_d;
            bubble_q   <= bubble_d;
            ld_rd_q    <= ld_rd_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.out_instr = head_present ? head.instr : 32'd0;
    assign bus.out_pc    = head_present ? head.pc   : 64'd0;
    assign bus.out_imm   = head_present ? head.imm  : 64'd0;
    assign bus.out_fmt   = head_present ? head.fmt  : FMT_OTHER;

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    // Flush does not clear the counter; it only restarts on reset.
    always_comb begin
        perf_d = perf_q;
        if (head_present && stall) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_q <= 32'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_bubbles = perf_q;
`endif

endmodule
